// File: rtl/shift_sequencer.sv
// shift_sequencer: command FIFO plus sequencer that drives an external 8-bit
// barrel shifter. Rotates and arithmetic right shifts take two passes.
module shift_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic [2:0] cmd_shamt,
    input  logic       cmd_dir,
    input  logic [1:0] cmd_op,
    output logic [7:0] sh_in,
    output logic [2:0] sh_shamt,
    output logic       sh_dir,
    input  logic [7:0] sh_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_LOG = 2'b00;
    localparam logic [1:0] OP_ROT = 2'b01;
    localparam logic [1:0] OP_ARI = 2'b10;
    localparam logic [1:0] OP_ALT = 2'b11;

    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic       dir;
        logic [2:0] shamt;
        logic [7:0] data;
    } cmd_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       wd_q, wd_d;
    logic [2:0]       wk_q, wk_d;
    logic             wdir_q, wdir_d;
    logic [1:0]       wop_q, wop_d;
    logic [7:0]       part_q, part_d;
    logic [7:0]       sh_in_q, sh_in_d;
    logic [2:0]       sh_shamt_q, sh_shamt_d;
    logic             sh_dir_q, sh_dir_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_data_q, res_data_d;

    cmd_t             mem_q [DEPTH];
    cmd_t             cmd_in_c;
    cmd_t             head_c;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;

    assign cmd_in_c  = '{op: cmd_op, dir: cmd_dir, shamt: cmd_shamt, data: cmd_data};
    assign head_c    = mem_q[rd_ptr_q];
    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign push_c    = cmd_valid && cmd_ready;
    assign pop_c     = (state_q == IDLE) && !empty_c;

    assign cmd_ready = !full_c && !rst;
    assign busy      = (state_q != IDLE) || !empty_c;
    assign sh_in     = sh_in_q;
    assign sh_shamt  = sh_shamt_q;
    assign sh_dir    = sh_dir_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
        end
    end

    // Next-state: FIFO pointers/count, sequencer FSM and shifter drive
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wd_d        = wd_q;
        wk_d        = wk_q;
        wdir_d      = wdir_q;
        wop_d       = wop_q;
        part_d      = part_q;
        sh_in_d     = 8'h00;
        sh_shamt_d  = 3'd0;
        sh_dir_d    = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (pop_c) begin
                    wd_d       = head_c.data;
                    wk_d       = head_c.shamt;
                    wdir_d     = head_c.dir;
                    wop_d      = (head_c.op == OP_ALT) ? OP_LOG : head_c.op;
                    sh_in_d    = head_c.data;
                    sh_shamt_d = head_c.shamt;
                    sh_dir_d   = (head_c.op == OP_ARI) ? 1'b1 : head_c.dir;
                    state_d    = P1;
                end
            end
            P1: begin
                part_d = sh_out;
                if ((wop_q == OP_LOG) || ((wop_q == OP_ROT) && (wk_q == 3'd0))) begin
                    res_data_d  = sh_out;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (wop_q == OP_ROT) begin
                    // Complementary shift fills the bits that fell off the first pass
                    sh_in_d    = wd_q;
                    sh_shamt_d = 3'(4'd8 - {1'b0, wk_q});
                    sh_dir_d   = ~wdir_q;
                    state_d    = P2;
                end else begin
                    // All-ones shifted right marks which high bits need sign fill
                    sh_in_d    = 8'hFF;
                    sh_shamt_d = wk_q;
                    sh_dir_d   = 1'b1;
                    state_d    = P2;
                end
            end
            P2: begin
                if (wop_q == OP_ROT) begin
                    res_data_d = part_q | sh_out;
                end else begin
                    res_data_d = wd_q[7] ? (part_q | ~sh_out) : part_q;
                end
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight command and flushes the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wd_q        <= 8'h00;
            wk_q        <= 3'd0;
            wdir_q      <= 1'b0;
            wop_q       <= OP_LOG;
            part_q      <= 8'h00;
            sh_in_q     <= 8'h00;
            sh_shamt_q  <= 3'd0;
            sh_dir_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            wk_q        <= wk_d;
            wdir_q      <= wdir_d;
            wop_q       <= wop_d;
            part_q      <= part_d;
            sh_in_q     <= sh_in_d;
            sh_shamt_q  <= sh_shamt_d;
            sh_dir_q    <= sh_dir_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with a behavioural barrel shifter.
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_shamt;
    logic       cmd_dir;
    logic [1:0] cmd_op;
    logic [7:0] sh_in;
    logic [2:0] sh_shamt;
    logic       sh_dir;
    logic [7:0] sh_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_shamt (cmd_shamt),
        .cmd_dir   (cmd_dir),
        .cmd_op    (cmd_op),
        .sh_in     (sh_in),
        .sh_shamt  (sh_shamt),
        .sh_dir    (sh_dir),
        .sh_out    (sh_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    // External logical barrel shifter
    assign sh_out = sh_dir ? (sh_in >> sh_shamt) : (sh_in << sh_shamt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [7:0] d, input logic [2:0] k,
                             input logic dir, input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_shamt = k;
        cmd_dir   = dir;
        cmd_op    = op;
    endtask

    // One command end to end: result value, latency, and release after handshake
    task automatic run_cmd(input string name, input logic [7:0] d, input logic [2:0] k,
                           input logic dir, input logic [1:0] op,
                           input logic [7:0] exp, input int exp_lat);
        int lat;
        drive_cmd(d, k, dir, op);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready got=%b want=1", name, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
        end
        checks++;
        if (res_data !== exp) begin
            failures++;
            $display("FAIL %s_data got=%h want=%h", name, res_data, exp);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_release valid=%b busy=%b want=0,0", name, res_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        cmd_shamt = 3'd0;
        cmd_dir   = 1'b0;
        cmd_op    = 2'b00;
        res_ready = 1'b0;
        #3;
        checks++;
        if ({cmd_ready, busy, res_valid, res_data, sh_in, sh_shamt, sh_dir} !== 23'd0) begin
            failures++;
            $display("FAIL reset_values rdy=%b busy=%b v=%b d=%h shin=%h k=%h dir=%b want all 0",
                     cmd_ready, busy, res_valid, res_data, sh_in, sh_shamt, sh_dir);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release rdy=%b busy=%b want=1,0", cmd_ready, busy);
        end
    endtask

    task automatic test_logical();
        run_cmd("lsl",   8'hB5, 3'd3, 1'b0, 2'b00, 8'hA8, 2);
        run_cmd("lsr",   8'hB5, 3'd3, 1'b1, 2'b00, 8'h16, 2);
        run_cmd("op11",  8'hB5, 3'd3, 1'b0, 2'b11, 8'hA8, 2);
        run_cmd("lsl_7", 8'hFF, 3'd7, 1'b0, 2'b00, 8'h80, 2);
    endtask

    task automatic test_rotate();
        run_cmd("rol",   8'hB5, 3'd3, 1'b0, 2'b01, 8'hAD, 3);
        run_cmd("ror",   8'hB5, 3'd3, 1'b1, 2'b01, 8'hB6, 3);
        run_cmd("rot0",  8'hB5, 3'd0, 1'b0, 2'b01, 8'hB5, 2);
        run_cmd("rol_1", 8'h81, 3'd1, 1'b0, 2'b01, 8'h03, 3);
    endtask

    task automatic test_arith();
        run_cmd("asr_neg", 8'hB5, 3'd3, 1'b0, 2'b10, 8'hF6, 3);
        run_cmd("asr_pos", 8'h35, 3'd3, 1'b1, 2'b10, 8'h06, 3);
        run_cmd("asr_max", 8'h80, 3'd7, 1'b0, 2'b10, 8'hFF, 3);
        run_cmd("asr_0",   8'h92, 3'd0, 1'b0, 2'b10, 8'h92, 3);
    endtask

    task automatic test_backpressure();
        logic [7:0] vd  [5] = '{8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hB5};
        logic [2:0] vk  [5] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
        logic       vdr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] vop [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        logic [7:0] vex [5] = '{8'hA8, 8'hAD, 8'hF6, 8'h16, 8'hB6};
        int guard;
        int got;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(vd[i], vk[i], vdr[i], vop[i]);
            guard = 0;
            while (cmd_ready !== 1'b1 && guard < 10) begin
                tick();
                guard++;
            end
            checks++;
            if (guard !== 0) begin
                failures++;
                $display("FAIL bp_accept_%0d stall_cycles=%0d want=0", i, guard);
            end
            tick();
        end
        // Sixth command is offered while full and must be held off
        drive_cmd(8'h11, 3'd1, 1'b0, 2'b00);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 8'hA8) begin
                failures++;
                $display("FAIL bp_stall_%0d rdy=%b v=%b d=%h want=0,1,a8",
                         c, cmd_ready, res_valid, res_data);
            end
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        got   = 0;
        guard = 0;
        while (got < 5 && guard < 60) begin
            if (res_valid === 1'b1) begin
                checks++;
                if (res_data !== vex[got]) begin
                    failures++;
                    $display("FAIL bp_order_%0d got=%h want=%h", got, res_data, vex[got]);
                end
                got++;
            end
            tick();
            guard++;
        end
        checks++;
        if (got !== 5) begin
            failures++;
            $display("FAIL bp_count got=%0d want=5", got);
        end
        tick();
        tick();
        res_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain rdy=%b busy=%b v=%b want=1,0,0", cmd_ready, busy, res_valid);
        end
    endtask

    task automatic test_reset_midcmd();
        int stale;
        res_ready = 1'b0;
        drive_cmd(8'hB5, 3'd3, 1'b0, 2'b01);
        tick();
        drive_cmd(8'h22, 3'd1, 1'b0, 2'b00);
        tick();
        drive_cmd(8'h33, 3'd2, 1'b1, 2'b00);
        tick();
        cmd_valid = 1'b0;
        // Second pass of rol 3 drives shift left-by-5 reversed, i.e. right by 5
        checks++;
        if (sh_shamt !== 3'd5 || sh_dir !== 1'b1 || sh_in !== 8'hB5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midcmd_p2 shin=%h k=%0d dir=%b busy=%b want=b5,5,1,1",
                     sh_in, sh_shamt, sh_dir, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy, res_valid, res_data, sh_in, sh_shamt, sh_dir} !== 23'd0) begin
            failures++;
            $display("FAIL midcmd_reset rdy=%b busy=%b v=%b d=%h shin=%h k=%h dir=%b want all 0",
                     cmd_ready, busy, res_valid, res_data, sh_in, sh_shamt, sh_dir);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL midcmd_flushed busy=%b v=%b want=0,0", busy, res_valid);
        end
        run_cmd("post_reset", 8'h01, 3'd1, 1'b0, 2'b00, 8'h02, 2);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (res_valid === 1'b1) stale++;
            tick();
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL midcmd_stale got=%0d want=0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_rotate();
        test_arith();
        test_backpressure();
        test_reset_midcmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
